// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/finish handshake and operand/result bundle for alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_hi;
  logic             ovf;
  logic [3:0]       condition;
  logic             busy;
  logic             finish;

  modport master (
    output start, opcode, data0, data1,
    input  out_data, out_hi, ovf, condition, busy, finish
  );

  modport slave (
    input  start, opcode, data0, data1,
    output out_data, out_hi, ovf, condition, busy, finish
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle arith/logic, iterative mul/div
module alu_seq #(parameter int WIDTH = 32) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;

  localparam logic [3:0] OP_OUT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR  = 4'h4, OP_NOR = 4'h5, OP_XOR = 4'h6, OP_SLL = 4'h7,
                         OP_SRL = 4'h8, OP_SRA = 4'h9, OP_MUL = 4'hA, OP_DIV = 4'hB,
                         OP_MULU = 4'hC, OP_DIVU = 4'hD, OP_SLT = 4'hE, OP_SLTU = 4'hF;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] hi_q, lo_q, mag_q, a_q;
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic [SHW-1:0]   cnt;
  logic             neg_res, neg_rem, div_zero, div_ovf, ovf_q;
  logic [3:0]       cond_q;

  logic [WIDTH-1:0] a, b, sum, diff, sc_res, ma, mb;
  logic [SHW-1:0]   sh;
  logic [3:0]       sc_cond;
  logic             sc_ovf, eq, lt_s, lt_u, multi, mul_start, signed_op, sa, sb;

  always_comb begin
    a       = bus.data0;
    b       = bus.data1;
    sh      = b[SHW-1:0];
    sum     = a + b;
    diff    = a - b;
    eq      = (a == b);
    lt_s    = ($signed(a) < $signed(b));
    lt_u    = (a < b);
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_cond = 4'b0000;
    case (bus.opcode)
      OP_OUT:  sc_res = a;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res  = diff;
        sc_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        sc_cond = {eq, ~eq, ~eq & ~lt_s, lt_s};
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOR:  sc_res = ~(a | b);
      OP_XOR:  sc_res = a ^ b;
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = $signed(a) >>> sh;
      OP_SLT: begin
        sc_res  = {{(WIDTH-1){1'b0}}, lt_s};
        sc_cond = {eq, ~eq, ~eq & ~lt_s, lt_s};
      end
      OP_SLTU: begin
        sc_res  = {{(WIDTH-1){1'b0}}, lt_u};
        sc_cond = {eq, ~eq, ~eq & ~lt_u, lt_u};
      end
      default: sc_res = '0;
    endcase
    mul_start = (bus.opcode == OP_MUL) || (bus.opcode == OP_MULU);
    multi     = mul_start || (bus.opcode == OP_DIV) || (bus.opcode == OP_DIVU);
    signed_op = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
    sa        = signed_op & a[WIDTH-1];
    sb        = signed_op & b[WIDTH-1];
    ma        = sa ? -a : a;
    mb        = sb ? -b : b;
  end

  // hi_q/lo_q hold {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_sub, step_hi, step_lo, q_fix, r_fix, fin_data, fin_hi;
  logic [2*WIDTH-1:0] prod;
  logic               div_ge, is_mul, fin_ovf;

  always_comb begin
    is_mul  = (op_q == OP_MUL) || (op_q == OP_MULU);
    mul_sum = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & mag_q};
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, mag_q});
    div_sub = div_sh[WIDTH-1:0] - mag_q;
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
    prod  = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
    q_fix = neg_res ? -step_lo : step_lo;
    r_fix = neg_rem ? -step_hi : step_hi;
    if (is_mul) begin
      fin_data = prod[WIDTH-1:0];
      fin_hi   = prod[2*WIDTH-1:WIDTH];
      fin_ovf  = (op_q == OP_MUL) ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                  : (|prod[2*WIDTH-1:WIDTH]);
    end else if (div_zero) begin
      fin_data = '1;
      fin_hi   = a_q;
      fin_ovf  = 1'b1;
    end else if (div_ovf) begin
      fin_data = MIN_VAL;
      fin_hi   = '0;
      fin_ovf  = 1'b1;
    end else begin
      fin_data = q_fix;
      fin_hi   = r_fix;
      fin_ovf  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_OUT;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_q    <= '0;
      a_q      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      ovf_q    <= 1'b0;
      cond_q   <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          op_q <= bus.opcode;
          a_q  <= a;
          cnt  <= '0;
          if (multi) begin
            state    <= S_CALC;
            hi_q     <= '0;
            mag_q    <= mul_start ? ma : mb;
            lo_q     <= mul_start ? mb : ma;
            neg_res  <= sa ^ sb;
            neg_rem  <= sa;
            div_zero <= (b == '0);
            div_ovf  <= signed_op && (a == MIN_VAL) && (b == '1);
          end else begin
            state    <= S_DONE;
            res_q    <= sc_res;
            res_hi_q <= '0;
            ovf_q    <= sc_ovf;
            cond_q   <= sc_cond;
          end
        end
        S_CALC: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH-1)) begin
            state    <= S_DONE;
            res_q    <= fin_data;
            res_hi_q <= fin_hi;
            ovf_q    <= fin_ovf;
            cond_q   <= 4'b0000;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data  = res_q;
  assign bus.out_hi    = res_hi_q;
  assign bus.ovf       = ovf_q;
  assign bus.condition = cond_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.finish    = (state == S_DONE);
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH 32 and 8
module tb_alu_seq;
  typedef struct {
    logic [63:0] data;
    logic [63:0] hi;
    logic        ovf;
    logic [3:0]  cond;
    int          lat;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    logic [63:0] hi;
    logic        ovf;
    logic [3:0]  cond;
    logic        busy;
    logic        fin;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) b32 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      b32.start = st; b32.opcode = op; b32.data0 = a[31:0]; b32.data1 = b[31:0];
    end else begin
      b8.start = st; b8.opcode = op; b8.data0 = a[7:0]; b8.data1 = b[7:0];
    end
  endtask

  function automatic obs_t sample(input int w);
    obs_t o;
    if (w == 32) begin
      o.data = 64'(b32.out_data); o.hi = 64'(b32.out_hi); o.ovf = b32.ovf;
      o.cond = b32.condition; o.busy = b32.busy; o.fin = b32.finish;
    end else begin
      o.data = 64'(b8.out_data); o.hi = 64'(b8.out_hi); o.ovf = b8.ovf;
      o.cond = b8.condition; o.busy = b8.busy; o.fin = b8.finish;
    end
    return o;
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input logic [63:0] h, input logic v,
                              input logic [3:0] c, input int lat);
    exp_t e;
    e.data = d; e.hi = h; e.ovf = v; e.cond = c; e.lat = lat;
    return e;
  endfunction

  function automatic logic [3:0] cmp(input logic lt, input logic eq);
    return {eq, ~eq, ~eq & ~lt, lt};
  endfunction

  // Reference model in 64-bit integer arithmetic, truncated to w bits
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] ai,
                                 input logic [63:0] bi, input int w);
    exp_t        e;
    logic [63:0] mask, a, b, up;
    longint      as, bs, p, lo_lim, hi_lim;
    int          sh;
    mask   = (64'd1 << w) - 64'd1;
    a      = ai & mask;
    b      = bi & mask;
    as     = a[w-1] ? longint'(a | ~mask) : longint'(a);
    bs     = b[w-1] ? longint'(b | ~mask) : longint'(b);
    lo_lim = -(longint'(1) << (w - 1));
    hi_lim = (longint'(1) << (w - 1)) - 1;
    sh     = int'(b & 64'(w - 1));
    e      = mk(64'd0, 64'd0, 1'b0, 4'b0000, 1);
    case (op)
      4'h0: e.data = a;
      4'h1: begin p = as + bs; e.data = 64'(p) & mask; e.ovf = (p < lo_lim) || (p > hi_lim); end
      4'h2: begin
        p = as - bs; e.data = 64'(p) & mask; e.ovf = (p < lo_lim) || (p > hi_lim);
        e.cond = cmp(as < bs, as == bs);
      end
      4'h3: e.data = a & b;
      4'h4: e.data = a | b;
      4'h5: e.data = ~(a | b) & mask;
      4'h6: e.data = a ^ b;
      4'h7: e.data = (a << sh) & mask;
      4'h8: e.data = a >> sh;
      4'h9: e.data = 64'(as >>> sh) & mask;
      4'hA: begin
        p = as * bs; e.lat = w + 1;
        e.data = 64'(p) & mask; e.hi = 64'(p >>> w) & mask;
        e.ovf = (p < lo_lim) || (p > hi_lim);
      end
      4'hC: begin
        up = a * b; e.lat = w + 1;
        e.data = up & mask; e.hi = (up >> w) & mask; e.ovf = (e.hi != 64'd0);
      end
      4'hB: begin
        e.lat = w + 1;
        if (b == 64'd0) begin e.data = mask; e.hi = a; e.ovf = 1'b1; end
        else if (as == lo_lim && bs == -1) begin
          e.data = 64'(lo_lim) & mask; e.hi = 64'd0; e.ovf = 1'b1;
        end else begin
          e.data = 64'(as / bs) & mask; e.hi = 64'(as % bs) & mask;
        end
      end
      4'hD: begin
        e.lat = w + 1;
        if (b == 64'd0) begin e.data = mask; e.hi = a; e.ovf = 1'b1; end
        else begin e.data = a / b; e.hi = a % b; end
      end
      4'hE: begin e.data = 64'(as < bs); e.cond = cmp(as < bs, as == bs); end
      default: begin e.data = 64'(a < b); e.cond = cmp(a < b, a == b); end
    endcase
    return e;
  endfunction

  // poke: cycle after accept (1-based) at which a stray ADD start is asserted; 0 = never
  task automatic run_op(input int w, input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input exp_t e, input int poke);
    obs_t o;
    exp_t x;
    int   k;
    sb_q.push_back(e);
    k = 0;
    @(negedge clk);
    o = sample(w);
    while (o.busy && k < 200) begin @(negedge clk); o = sample(w); k++; end
    drive(w, 1'b1, op, a, b);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      o = sample(w);
      if (k == 1) check_val({tag, ".busy"}, 64'(o.busy), 64'd1);
      if (k == poke) drive(w, 1'b1, 4'h1, 64'd1, 64'd1);
      else drive(w, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    end while (!o.fin && k < 200);
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb"}, 64'd0, 64'd1);
      return;
    end
    x = sb_q.pop_front();
    check_val({tag, ".lat"}, 64'(k), 64'(x.lat));
    check_val({tag, ".data"}, o.data, x.data);
    check_val({tag, ".hi"}, o.hi, x.hi);
    check_val({tag, ".ovf"}, 64'(o.ovf), 64'(x.ovf));
    check_val({tag, ".cond"}, 64'(o.cond), 64'(x.cond));
    @(negedge clk);
    drive(w, 1'b0, 4'h0, 64'd0, 64'd0);
    o = sample(w);
    check_val({tag, ".fin_pulse"}, 64'(o.fin), 64'd0);
    check_val({tag, ".idle"}, 64'(o.busy), 64'd0);
    check_val({tag, ".held"}, o.data, x.data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t        o;
    logic [3:0]  op;
    logic [63:0] a, b;
    int          fins;

    drive(32, 1'b0, 4'h0, 64'd0, 64'd0);
    drive(8, 1'b0, 4'h0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    o = sample(32);
    check_val("rst.data", o.data, 64'd0);
    check_val("rst.hi", o.hi, 64'd0);
    check_val("rst.flags", {58'd0, o.ovf, o.busy, o.cond}, 64'd0);
    check_val("rst.fin", 64'(o.fin), 64'd0);

    run_op(32, "add_ovf", 4'h1, 64'h7FFFFFFF, 64'h1, mk(64'h80000000, 0, 1, 4'b0000, 1), 0);
    run_op(32, "sub_eq", 4'h2, 64'd5, 64'd5, mk(64'd0, 0, 0, 4'b1000, 1), 0);
    run_op(32, "sltu", 4'hF, 64'd1, 64'hFFFFFFFF, mk(64'd1, 0, 0, 4'b0101, 1), 0);
    run_op(32, "mul_neg", 4'hA, 64'hFFFFFFFD, 64'd7,
           mk(64'hFFFFFFEB, 64'hFFFFFFFF, 0, 4'b0000, 33), 0);
    run_op(32, "divu", 4'hD, 64'd100, 64'd7, mk(64'd14, 64'd2, 0, 4'b0000, 33), 0);
    run_op(32, "div_neg", 4'hB, 64'hFFFFFFF9, 64'd2,
           mk(64'hFFFFFFFD, 64'hFFFFFFFF, 0, 4'b0000, 33), 0);
    run_op(32, "div_zero", 4'hB, 64'd5, 64'd0, mk(64'hFFFFFFFF, 64'd5, 1, 4'b0000, 33), 0);
    run_op(32, "div_minm1", 4'hB, 64'h80000000, 64'hFFFFFFFF,
           mk(64'h80000000, 64'd0, 1, 4'b0000, 33), 0);
    run_op(32, "mulu_max", 4'hC, 64'hFFFFFFFF, 64'hFFFFFFFF,
           mk(64'd1, 64'hFFFFFFFE, 1, 4'b0000, 33), 0);
    run_op(32, "sra31", 4'h9, 64'h80000000, 64'd31, mk(64'hFFFFFFFF, 0, 0, 4'b0000, 1), 0);
    run_op(32, "sll32", 4'h7, 64'h12345678, 64'd32, mk(64'h12345678, 0, 0, 4'b0000, 1), 0);
    run_op(32, "busy_poke", 4'hA, 64'd9, 64'hFFFFFFFC,
           mk(64'hFFFFFFDC, 64'hFFFFFFFF, 0, 4'b0000, 33), 3);
    run_op(32, "done_poke", 4'h6, 64'hF0F0F0F0, 64'h0FF00FF0,
           mk(64'hFF00FF00, 0, 0, 4'b0000, 1), 1);

    @(negedge clk);
    drive(32, 1'b1, 4'hB, 64'd1000, 64'd3);
    @(negedge clk);
    drive(32, 1'b0, 4'h0, 64'd0, 64'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fins = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample(32).fin) fins++;
    end
    o = sample(32);
    check_val("abort.fin", 64'(fins), 64'd0);
    check_val("abort.data", o.data, 64'd0);
    check_val("abort.hi", o.hi, 64'd0);
    check_val("abort.busy", 64'(o.busy), 64'd0);

    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = (i % 4 == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      run_op(32, $sformatf("r32_%0d_op%0h", i, op), op, a, b, model(op, a, b, 32), 0);
    end

    run_op(8, "w8_add_ovf", 4'h1, 64'h7F, 64'h01, mk(64'h80, 0, 1, 4'b0000, 1), 0);
    run_op(8, "w8_mul_min", 4'hA, 64'h80, 64'h80, mk(64'h00, 64'h40, 1, 4'b0000, 9), 0);
    run_op(8, "w8_div_minm1", 4'hB, 64'h80, 64'hFF, mk(64'h80, 64'h00, 1, 4'b0000, 9), 0);
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 64'($urandom_range(0, 255));
      b  = (i % 4 == 0) ? 64'($urandom_range(0, 2)) : 64'($urandom_range(0, 255));
      run_op(8, $sformatf("r8_%0d_op%0h", i, op), op, a, b, model(op, a, b, 8), 0);
    end

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
